// File: rtl/fft_bfly_periph.sv
// fft_bfly_periph: radix-2 DIT butterfly accelerator on the openMSP430 peripheral bus.
// Computes Y0 = A + B*W and Y1 = A - B*W with one time-shared 16x16 multiplier.
// Ports:
//   mclk      system clock
//   puc_rst   asynchronous active-high reset
//   per_addr  word address; per_din write data; per_en access strobe; per_we byte enables
//   per_dout  read data (0 when unselected or on a write)
//   irq_done  level interrupt, DONE & IE
module fft_bfly_periph #(
    parameter logic [14:0] BASE_ADDR = 15'h0180,
    parameter int          FRAC_BITS = 15,
    parameter bit          SAT_EN    = 1'b1
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic        irq_done
);
    typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_M3, S_ADD} state_t;
    localparam logic signed [33:0] RND = 34'sd1 <<< (FRAC_BITS - 1);
    state_t             state_q;
    logic [15:0]        op_q [6];
    logic [15:0]        op_d [6];
    logic [15:0]        sh_q [6];
    logic [15:0]        y_q [4];
    logic [16:0]        fin_v [4];
    logic signed [32:0] tr_q, ti_q, p;
    logic signed [33:0] trr, tir, a_r, a_i;
    logic signed [31:0] prod;
    logic [15:0]        ma, mb;
    logic               inv_q, scale_q, auto_q, ie_q, inv_d, scale_d, auto_d, ie_d;
    logic               sinv_q, sscale_q;
    logic               done_q, ovf_q, err_q, done_d, ovf_d, err_d;
    logic               sel, wr_en, rd_en, ctrl_wr, stat_wr, busy, start_req, start, ovf_set;
    logic [3:0]         idx;

    function automatic logic signed [33:0] sx(input logic [15:0] x);
        return $signed({{18{x[15]}}, x});
    endfunction

    // Optional halving, then range check; returns {overflow, stored value}.
    function automatic logic [16:0] fin(input logic signed [33:0] v, input logic sc);
        logic signed [33:0] s;
        logic               o;
        s = sc ? v >>> 1 : v;
        o = (s > 34'sd32767) || (s < -34'sd32768);
        return {o, (o && SAT_EN) ? (s[33] ? 16'h8000 : 16'h7FFF) : s[15:0]};
    endfunction

    assign sel       = per_en && (per_addr[13:4] == BASE_ADDR[14:5]);
    assign idx       = per_addr[3:0];
    assign wr_en     = sel && (per_we == 2'b11);
    assign rd_en     = sel && (per_we == 2'b00);
    assign ctrl_wr   = wr_en && (idx == 4'd6);
    assign stat_wr   = wr_en && (idx == 4'd7);
    assign busy      = state_q != S_IDLE;
    assign start_req = (ctrl_wr && per_din[0]) || (wr_en && (idx == 4'd5) && auto_q);
    assign start     = start_req && !busy;
    assign inv_d     = ctrl_wr ? per_din[1] : inv_q;
    assign scale_d   = ctrl_wr ? per_din[2] : scale_q;
    assign auto_d    = ctrl_wr ? per_din[3] : auto_q;
    assign ie_d      = ctrl_wr ? per_din[4] : ie_q;
    assign irq_done  = done_q & ie_q;

    always_comb begin
        op_d = op_q;
        if (wr_en && idx < 4'd6) op_d[idx[2:0]] = per_din;
    end

    // Operand order per state: M0 BR*WR, M1 BI*WI, M2 BI*WR, M3 BR*WI.
    assign ma   = (state_q == S_M0 || state_q == S_M3) ? sh_q[2] : sh_q[3];
    assign mb   = (state_q == S_M0 || state_q == S_M2) ? sh_q[4] : sh_q[5];
    assign prod = $signed(ma) * $signed(mb);
    assign p    = $signed({prod[31], prod});

    assign trr = ($signed({tr_q[32], tr_q}) + RND) >>> FRAC_BITS;
    assign tir = ($signed({ti_q[32], ti_q}) + RND) >>> FRAC_BITS;
    assign a_r = sx(sh_q[0]);
    assign a_i = sx(sh_q[1]);
    assign fin_v[0] = fin(a_r + trr, sscale_q);
    assign fin_v[1] = fin(a_i + tir, sscale_q);
    assign fin_v[2] = fin(a_r - trr, sscale_q);
    assign fin_v[3] = fin(a_i - tir, sscale_q);
    assign ovf_set  = (state_q == S_ADD) && (fin_v[0][16] | fin_v[1][16] | fin_v[2][16] | fin_v[3][16]);

    // Hardware set wins over write-1-to-clear; an accepted start also clears DONE.
    assign done_d = (state_q == S_ADD) | (done_q & ~(stat_wr & per_din[1]) & ~start);
    assign ovf_d  = ovf_set | (ovf_q & ~(stat_wr & per_din[2]));
    assign err_d  = (start_req & busy) | (err_q & ~(stat_wr & per_din[3]));

    always_comb begin
        per_dout = '0;
        if (rd_en)
            per_dout = (idx < 4'd6)        ? op_q[idx[2:0]] :
                       (idx == 4'd6)       ? {11'b0, ie_q, auto_q, scale_q, inv_q, 1'b0} :
                       (idx == 4'd7)       ? {12'b0, err_q, ovf_q, done_q, busy} :
                       (idx[3:2] == 2'b10) ? y_q[idx[1:0]] : 16'h0000;
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q  <= S_IDLE;
            op_q     <= '{default: '0};
            sh_q     <= '{default: '0};
            y_q      <= '{default: '0};
            tr_q     <= '0;
            ti_q     <= '0;
            inv_q    <= 1'b0;
            scale_q  <= 1'b0;
            auto_q   <= 1'b0;
            ie_q     <= 1'b0;
            sinv_q   <= 1'b0;
            sscale_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            op_q    <= op_d;
            inv_q   <= inv_d;
            scale_q <= scale_d;
            auto_q  <= auto_d;
            ie_q    <= ie_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            if (start) begin
                sh_q     <= op_d;
                sinv_q   <= inv_d;
                sscale_q <= scale_d;
            end
            state_q <= start ? S_M0 :
                       (state_q == S_ADD || state_q == S_IDLE) ? S_IDLE : state_t'(state_q + 3'd1);
            case (state_q)
                S_M0:    tr_q <= p;
                S_M1:    tr_q <= sinv_q ? tr_q + p : tr_q - p;
                S_M2:    ti_q <= p;
                S_M3:    ti_q <= sinv_q ? ti_q - p : ti_q + p;
                S_ADD:   for (int i = 0; i < 4; i++) y_q[i] <= fin_v[i][15:0];
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_bfly_periph.sv
// tb_fft_bfly_periph: directed vector bench for fft_bfly_periph.
module tb_fft_bfly_periph;
    localparam logic [9:0] BW = 10'h00C;
    logic        mclk = 1'b0, puc_rst = 1'b1;
    logic [13:0] per_addr = '0;
    logic [15:0] per_din = '0;
    logic        per_en = 1'b0;
    logic [1:0]  per_we = 2'b00;
    logic [15:0] per_dout, dout2;
    logic        irq_done, irq2;
    int          total = 0, bad = 0;

    typedef struct packed {
        logic [15:0] a_r, a_i, b_r, b_i, w_r, w_i, ctrl, y0r, y0i, y1r, y1i, y0r2;
        logic [3:0]  st;
    } vec_t;
    vec_t v [8];

    always #5 mclk = ~mclk;

    fft_bfly_periph #(.BASE_ADDR(15'h0180), .FRAC_BITS(15), .SAT_EN(1'b1)) dut (
        .mclk(mclk), .puc_rst(puc_rst), .per_addr(per_addr), .per_din(per_din),
        .per_en(per_en), .per_we(per_we), .per_dout(per_dout), .irq_done(irq_done));

    fft_bfly_periph #(.BASE_ADDR(15'h0180), .FRAC_BITS(15), .SAT_EN(1'b0)) dut_wrap (
        .mclk(mclk), .puc_rst(puc_rst), .per_addr(per_addr), .per_din(per_din),
        .per_en(per_en), .per_we(per_we), .per_dout(dout2), .irq_done(irq2));

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] we = 2'b11);
        per_en = 1'b1; per_addr = {BW, a}; per_din = d; per_we = we;
        @(negedge mclk);
        per_en = 1'b0; per_we = 2'b00;
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] d, output logic [15:0] d2);
        per_en = 1'b1; per_addr = {BW, a}; per_we = 2'b00;
        #1 d = per_dout; d2 = dout2;
        per_en = 1'b0;
        @(negedge mclk);
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [15:0] exp, input string name);
        logic [15:0] d, d2;
        rd(a, d, d2);
        chk(name, d, exp);
    endtask

    task automatic wait_done();
        logic [15:0] s, s2;
        int n = 0;
        do begin
            rd(4'd7, s, s2);
            n++;
        end while (s[0] && n < 20);
        chk("busy_timeout", {15'b0, s[0]}, 16'h0000);
    endtask

    task automatic set_ops(input vec_t x);
        wr(4'd0, x.a_r); wr(4'd1, x.a_i); wr(4'd2, x.b_r);
        wr(4'd3, x.b_i); wr(4'd4, x.w_r); wr(4'd5, x.w_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] d, d2;
        int b;
        v[0] = '{16'h4000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0001,
                 16'h6000, 16'h0000, 16'h2000, 16'h0000, 16'h6000, 4'b0010};
        v[1] = '{16'h4000, 16'h0000, 16'h2000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0001,
                 16'h4000, 16'h2000, 16'h4000, 16'hE000, 16'h4000, 4'b0010};
        v[2] = '{16'h4000, 16'h0000, 16'h2000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0003,
                 16'h4000, 16'hE000, 16'h4000, 16'h2000, 16'h4000, 4'b0010};
        v[3] = '{16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h0001,
                 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 16'hFFFD, 4'b0110};
        v[4] = '{16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h0005,
                 16'h7FFE, 16'h0000, 16'h0000, 16'h0000, 16'h7FFE, 4'b0010};
        v[5] = '{16'h0000, 16'h0000, 16'hC000, 16'h0000, 16'h8000, 16'h0000, 16'h0001,
                 16'h4000, 16'h0000, 16'hC000, 16'h0000, 16'h4000, 4'b0010};
        v[6] = '{16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h4000, 16'h0001,
                 16'hE000, 16'h0000, 16'h2000, 16'h0000, 16'hE000, 4'b0010};
        v[7] = '{16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h4000, 16'h0003,
                 16'h2000, 16'h0000, 16'hE000, 16'h0000, 16'h2000, 4'b0010};

        repeat (2) @(negedge mclk);
        puc_rst = 1'b0;
        @(negedge mclk);

        for (int i = 0; i < 16; i++) rd_chk(4'(i), 16'h0000, $sformatf("reset_reg%0d", i));
        chk("reset_irq", {15'b0, irq_done}, 16'h0000);
        wr(4'd0, 16'h1234, 2'b01);
        rd_chk(4'd0, 16'h0000, "byte_write_lo");
        wr(4'd0, 16'h1234, 2'b10);
        rd_chk(4'd0, 16'h0000, "byte_write_hi");
        wr(4'd0, 16'h1234);
        rd_chk(4'd0, 16'h1234, "ar_readback");
        per_en = 1'b1; per_addr = {10'h00D, 4'h0}; per_we = 2'b00;
        #1 chk("unselected_read", per_dout, 16'h0000);
        per_en = 1'b0;
        @(negedge mclk);

        set_ops(v[0]);
        wr(4'd7, 16'h000E);
        wr(4'd6, 16'h0001);
        b = 0;
        for (int i = 0; i < 10; i++) begin
            rd(4'd7, d, d2);
            b += int'(d[0]);
        end
        chk("busy_cycles", 16'(b), 16'd5);
        rd_chk(4'd7, 16'h0002, "done_after_fwd");

        for (int i = 0; i < 8; i++) begin
            wr(4'd7, 16'h000E);
            set_ops(v[i]);
            wr(4'd6, v[i].ctrl);
            wait_done();
            rd_chk(4'd8, v[i].y0r, $sformatf("v%0d_y0r", i));
            rd_chk(4'd9, v[i].y0i, $sformatf("v%0d_y0i", i));
            rd_chk(4'd10, v[i].y1r, $sformatf("v%0d_y1r", i));
            rd_chk(4'd11, v[i].y1i, $sformatf("v%0d_y1i", i));
            rd_chk(4'd7, {12'b0, v[i].st}, $sformatf("v%0d_stat", i));
            rd(4'd8, d, d2);
            chk($sformatf("v%0d_y0r_wrap", i), d2, v[i].y0r2);
        end

        wr(4'd7, 16'h000E);
        wr(4'd6, 16'h0008);
        wr(4'd0, 16'h4000); wr(4'd1, 16'h0000); wr(4'd2, 16'h2000);
        wr(4'd3, 16'h0000); wr(4'd4, 16'h7FFF);
        rd_chk(4'd7, 16'h0000, "auto_idle_before_wi");
        wr(4'd5, 16'h0000);
        wr(4'd6, 16'h0009);
        wr(4'd0, 16'h1000);
        wait_done();
        rd_chk(4'd8, 16'h6000, "auto_y0r");
        rd_chk(4'd10, 16'h2000, "auto_y1r");
        rd_chk(4'd7, 16'h000A, "auto_err_done");
        wr(4'd7, 16'h0008);
        rd_chk(4'd7, 16'h0002, "err_cleared");
        wr(4'd6, 16'h0000);

        wr(4'd7, 16'h000E);
        set_ops(v[0]);
        wr(4'd6, 16'h0011);
        chk("irq_low_while_busy", {15'b0, irq_done}, 16'h0000);
        wait_done();
        chk("irq_high", {15'b0, irq_done}, 16'h0001);
        chk("irq_high_wrap", {15'b0, irq2}, 16'h0001);
        wr(4'd7, 16'h0002);
        #1 chk("irq_cleared", {15'b0, irq_done}, 16'h0000);
        wr(4'd6, 16'h0010);
        wr(4'd7, 16'h000E);
        set_ops(v[1]);
        wr(4'd6, 16'h0011);
        @(negedge mclk);
        @(negedge mclk);
        puc_rst = 1'b1;
        @(negedge mclk);
        puc_rst = 1'b0;
        rd_chk(4'd7, 16'h0000, "rst_mid_stat");
        rd_chk(4'd8, 16'h0000, "rst_mid_y0r");
        rd_chk(4'd9, 16'h0000, "rst_mid_y0i");
        rd_chk(4'd6, 16'h0000, "rst_mid_ctrl");
        chk("rst_mid_irq", {15'b0, irq_done}, 16'h0000);
        set_ops(v[0]);
        wr(4'd6, 16'h0001);
        wait_done();
        rd_chk(4'd8, 16'h6000, "post_rst_y0r");
        rd_chk(4'd10, 16'h2000, "post_rst_y1r");
        rd_chk(4'd7, 16'h0002, "post_rst_stat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
